// File: rtl/sdcard_block_reader.sv
// Reads one SD card block with CMD17 through an SPI interface register file; the data moves by hardware DMA.
// Define SDCARD_CRC_CHECK_EN to add the CHECK state, which inspects the CRC residue registers after the read.

module sdcard_block_reader #(
    parameter logic [4:0] SPI_BITS    = 5'h07,
    parameter int         R1_TRIES    = 8,
    parameter int         TOKEN_TRIES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [31:0] blk_addr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [2:0]  bus_a,
    output logic [7:0]  bus_wd,
    input  logic [7:0]  bus_rd,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [3:0]  dbg_state
);

    // Handshake: a one-cycle req in IDLE is accepted; busy rises next cycle and
    // falls with the one-cycle done pulse, when err_code becomes valid.
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_CMD, S_R1, S_TOKEN, S_CRCCLR,
        S_DMA, S_DMAWAIT, S_CRCRD, S_CHECK, S_FIN
    } state_t;

    typedef enum logic [1:0] {PH_WR, PH_POLL, PH_RD} phase_t;

    localparam logic [10:0] R1_LIM  = 11'(R1_TRIES);
    localparam logic [10:0] TOK_LIM = 11'(TOKEN_TRIES);

    state_t      r_state;
    phase_t      r_ph;
    logic [10:0] r_cnt;
    logic [31:0] r_addr;
    logic        r_busy;
    logic        r_done;
    logic [1:0]  r_err;
    logic        r_cs;
    logic        r_we;
    logic [2:0]  r_a;
    logic [7:0]  r_wd;
`ifdef SDCARD_CRC_CHECK_EN
    logic        r_crc_bad;
`endif

    logic [10:0] w_cnt_inc;
    logic [7:0]  w_cmd_byte;
    logic        w_fin;
    logic [1:0]  w_fin_err;

    assign w_cnt_inc = r_cnt + 11'd1;

    // Command byte that follows the one just completed (index r_cnt).
    always_comb begin
        w_cmd_byte = 8'hFF;
        case (r_cnt)
            11'd0:   w_cmd_byte = r_addr[31:24];
            11'd1:   w_cmd_byte = r_addr[23:16];
            11'd2:   w_cmd_byte = r_addr[15:8];
            11'd3:   w_cmd_byte = r_addr[7:0];
            default: w_cmd_byte = 8'hFF;
        endcase
    end

    // Termination decisions: errors, timeouts and the normal end of the read.
    always_comb begin
        w_fin     = 1'b0;
        w_fin_err = 2'b00;
        if (r_ph == PH_RD) begin
            case (r_state)
                S_R1: begin
                    if (bus_rd != 8'h00 && !bus_rd[7]) begin
                        w_fin = 1'b1; w_fin_err = 2'b01;
                    end else if (bus_rd[7] && w_cnt_inc == R1_LIM) begin
                        w_fin = 1'b1; w_fin_err = 2'b10;
                    end
                end
                S_TOKEN: begin
                    if (bus_rd != 8'hFE && bus_rd != 8'hFF) begin
                        w_fin = 1'b1; w_fin_err = 2'b01;
                    end else if (bus_rd == 8'hFF && w_cnt_inc == TOK_LIM) begin
                        w_fin = 1'b1; w_fin_err = 2'b10;
                    end
                end
`ifndef SDCARD_CRC_CHECK_EN
                S_CRCRD: if (r_cnt == 11'd1) w_fin = 1'b1;
`endif
                default: ;
            endcase
        end
`ifdef SDCARD_CRC_CHECK_EN
        if (r_state == S_CHECK && r_cnt == 11'd1) begin
            w_fin     = 1'b1;
            w_fin_err = (r_crc_bad || bus_rd != 8'h00) ? 2'b11 : 2'b00;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ph    <= PH_WR;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 2'b00;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_a     <= '0;
            r_wd    <= '0;
`ifdef SDCARD_CRC_CHECK_EN
            r_crc_bad <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_fin) begin
                r_state <= S_FIN;
                r_err   <= w_fin_err;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_ph    <= PH_WR;
                r_cs    <= 1'b0;
                r_we    <= 1'b0;
                r_a     <= '0;
                r_wd    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (req) begin
                        r_addr  <= blk_addr;
                        r_busy  <= 1'b1;
                        r_err   <= 2'b00;
                        r_cnt   <= '0;
                        r_state <= S_CFG;
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_a     <= 3'd0;
                        r_wd    <= {3'b000, SPI_BITS};
                    end
                    S_CFG: begin
                        r_state <= S_CMD;
                        r_ph    <= PH_WR;
                        r_cnt   <= '0;
                        r_a     <= 3'd1;
                        r_wd    <= 8'h51;
                    end
                    S_CMD, S_R1, S_TOKEN, S_CRCRD: begin
                        case (r_ph)
                            PH_WR: begin
                                r_ph <= PH_POLL;
                                r_we <= 1'b0;
                                r_a  <= 3'd0;
                                r_wd <= '0;
                            end
                            PH_POLL: if (bus_rd[7]) begin
                                r_ph <= PH_RD;
                                r_a  <= 3'd1;
                            end
                            default: begin
                                // Byte received; by default start the next 0xFF transfer.
                                r_ph  <= PH_WR;
                                r_we  <= 1'b1;
                                r_a   <= 3'd1;
                                r_wd  <= 8'hFF;
                                r_cnt <= w_cnt_inc;
                                case (r_state)
                                    S_CMD: begin
                                        if (r_cnt == 11'd5) begin
                                            r_state <= S_R1;
                                            r_cnt   <= '0;
                                        end else begin
                                            r_wd <= w_cmd_byte;
                                        end
                                    end
                                    S_R1: if (bus_rd == 8'h00) begin
                                        r_state <= S_TOKEN;
                                        r_cnt   <= '0;
                                    end
                                    S_TOKEN: if (bus_rd == 8'hFE) begin
                                        r_state <= S_CRCCLR;
                                        r_cnt   <= '0;
                                        r_a     <= 3'd4;
                                        r_wd    <= 8'h00;
                                    end
                                    default: begin
`ifdef SDCARD_CRC_CHECK_EN
                                        if (r_cnt == 11'd1) begin
                                            r_state   <= S_CHECK;
                                            r_cnt     <= '0;
                                            r_we      <= 1'b0;
                                            r_a       <= 3'd4;
                                            r_wd      <= 8'h00;
                                            r_crc_bad <= 1'b0;
                                        end
`endif
                                    end
                                endcase
                            end
                        endcase
                    end
                    S_CRCCLR: begin
                        if (r_cnt == 11'd0) begin
                            r_cnt <= 11'd1;
                            r_a   <= 3'd5;
                        end else begin
                            r_state <= S_DMA;
                            r_a     <= 3'd0;
                            r_wd    <= {3'b010, SPI_BITS};
                        end
                    end
                    S_DMA: begin
                        r_state <= S_DMAWAIT;
                        r_we    <= 1'b0;
                        r_wd    <= '0;
                    end
                    S_DMAWAIT: if (!bus_rd[6]) begin
                        r_state <= S_CRCRD;
                        r_ph    <= PH_WR;
                        r_cnt   <= '0;
                        r_we    <= 1'b1;
                        r_a     <= 3'd1;
                        r_wd    <= 8'hFF;
                    end
`ifdef SDCARD_CRC_CHECK_EN
                    S_CHECK: begin
                        r_crc_bad <= (bus_rd != 8'h00);
                        r_cnt     <= 11'd1;
                        r_a       <= 3'd5;
                    end
`endif
                    S_FIN:   r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err;
    assign bus_a     = r_a;
    assign bus_wd    = r_wd;
    assign bus_cs    = r_cs;
    assign bus_we    = r_we;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sdcard_block_reader.sv
// Bench for sdcard_block_reader: SPI interface + card model, scripted and random block reads.
// Expected results come from a per-read scenario model (poll positions, response bytes, CRC corruption).

module tb_sdcard_block_reader;

  localparam int R1_TRIES    = 8;
  localparam int TOKEN_TRIES = 1024;
  localparam logic [4:0] SPI_BITS = 5'h07;
`ifdef SDCARD_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] blk_addr = '0;
  logic        busy, done, bus_cs, bus_we;
  logic [1:0]  err_code;
  logic [2:0]  bus_a;
  logic [7:0]  bus_wd, bus_rd;
  logic [3:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  sdcard_block_reader #(
    .SPI_BITS(SPI_BITS), .R1_TRIES(R1_TRIES), .TOKEN_TRIES(TOKEN_TRIES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .blk_addr(blk_addr),
    .busy(busy), .done(done), .err_code(err_code),
    .bus_a(bus_a), .bus_wd(bus_wd), .bus_rd(bus_rd),
    .bus_cs(bus_cs), .bus_we(bus_we), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scenario for the current read
  int         sc_r1_at, sc_tok_at;
  logic [7:0] sc_r1_val, sc_tok_val;
  bit         sc_corrupt;

  // SPI interface + card model
  logic       avail = 1'b0, dma_busy = 1'b0;
  logic [7:0] rx_byte = 8'h00, pend_byte = 8'h00;
  logic [7:0] crc_lo = 8'h00, crc_hi = 8'h00;
  int         xfer_wait = 0, dma_wait = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  int         crc_clr_n = 0, dma_wr_n = 0, mode_wr_n = 0, mode_bad_n = 0;
  int         done_cnt = 0, prot_bad = 0;

  function automatic logic [7:0] card_byte(input int k);
    int j;
    if (k < 6) return 8'hFF;
    j = k - 6;
    if (j < sc_r1_at) return 8'hFF;
    if (j == sc_r1_at) return sc_r1_val;
    j = j - sc_r1_at - 1;
    if (j < sc_tok_at) return 8'hFF;
    if (j == sc_tok_at) return sc_tok_val;
    return 8'hA5;
  endfunction

  always_comb begin
    bus_rd = 8'h00;
    case (bus_a)
      3'd0:    bus_rd = {avail, dma_busy, 6'b0};
      3'd1:    bus_rd = rx_byte;
      3'd4:    bus_rd = crc_lo;
      3'd5:    bus_rd = crc_hi;
      default: bus_rd = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    int k;
    if (xfer_wait > 0) begin
      if (xfer_wait == 1) begin
        avail   <= 1'b1;
        rx_byte <= pend_byte;
      end
      xfer_wait <= xfer_wait - 1;
    end
    if (dma_wait > 0) begin
      if (dma_wait == 1) dma_busy <= 1'b0;
      dma_wait <= dma_wait - 1;
    end
    if (req && !busy && rst_n) begin
      tx_q.delete();
      crc_lo     <= 8'($urandom_range(1, 255));
      crc_hi     <= 8'($urandom_range(1, 255));
      crc_clr_n  <= 0;
      dma_wr_n   <= 0;
      mode_wr_n  <= 0;
      mode_bad_n <= 0;
    end
    if (bus_cs && bus_we) begin
      case (bus_a)
        3'd1: begin
          k = tx_q.size();
          tx_q.push_back(bus_wd);
          pend_byte <= card_byte(k);
          avail     <= 1'b0;
          xfer_wait <= $urandom_range(1, 3);
          if (sc_corrupt && k == 6 + sc_r1_at + 1 + sc_tok_at + 1) crc_lo <= 8'h21;
        end
        3'd0: begin
          mode_wr_n <= mode_wr_n + 1;
          if (bus_wd[7] || bus_wd[5] || bus_wd[4:0] != SPI_BITS) mode_bad_n <= mode_bad_n + 1;
          if (bus_wd[6]) begin
            dma_wr_n <= dma_wr_n + 1;
            dma_busy <= 1'b1;
            dma_wait <= $urandom_range(20, 60);
          end else begin
            dma_busy <= 1'b0;
            dma_wait <= 0;
          end
        end
        3'd4: begin crc_lo <= 8'h00; crc_clr_n <= crc_clr_n + 1; end
        3'd5: begin crc_hi <= 8'h00; crc_clr_n <= crc_clr_n + 1; end
        default: ;
      endcase
    end
  end

  // done pulses and bus protocol, sampled away from the active edge
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if ((bus_we && !bus_cs) || (!busy && bus_cs)) prot_bad <= prot_bad + 1;
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_scenario(input int r1_at, input logic [7:0] r1_val, input int tok_at,
                              input logic [7:0] tok_val, input bit corrupt);
    sc_r1_at = r1_at; sc_r1_val = r1_val; sc_tok_at = tok_at;
    sc_tok_val = tok_val; sc_corrupt = corrupt;
  endtask

  task automatic pulse_req(input logic [31:0] addr);
    @(negedge clk);
    req = 1'b1;
    blk_addr = addr;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] addr, input int r1_at,
                        input logic [7:0] r1_val, input int tok_at, input logic [7:0] tok_val,
                        input bit corrupt);
    int start_done, start_prot, cyc, exp_tx, exp_clr, exp_dma, non_ff;
    logic [1:0] exp_err;
    set_scenario(r1_at, r1_val, tok_at, tok_val, corrupt);
    exp_clr = 0;
    exp_dma = 0;
    if (r1_at >= R1_TRIES) begin
      exp_err = 2'b10; exp_tx = 6 + R1_TRIES;
    end else if (r1_val != 8'h00) begin
      exp_err = 2'b01; exp_tx = 6 + r1_at + 1;
    end else if (tok_at >= TOKEN_TRIES) begin
      exp_err = 2'b10; exp_tx = 6 + r1_at + 1 + TOKEN_TRIES;
    end else if (tok_val != 8'hFE) begin
      exp_err = 2'b01; exp_tx = 6 + r1_at + 1 + tok_at + 1;
    end else begin
      exp_err = (corrupt && CRC_EN) ? 2'b11 : 2'b00;
      exp_tx  = 6 + r1_at + 1 + tok_at + 1 + 2;
      exp_clr = 2;
      exp_dma = 1;
    end
    exp_q.delete();
    exp_q.push_back(8'h51);
    exp_q.push_back(addr[31:24]);
    exp_q.push_back(addr[23:16]);
    exp_q.push_back(addr[15:8]);
    exp_q.push_back(addr[7:0]);
    exp_q.push_back(8'hFF);

    start_done = done_cnt;
    start_prot = prot_bad;
    pulse_req(addr);
    check({name, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done_cnt == start_done && cyc < 30000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, "_no_timeout"}, 32'(cyc < 30000), 32'd1);
    repeat (3) @(negedge clk);

    check({name, "_done_once"}, 32'(done_cnt - start_done), 32'd1);
    check({name, "_err"}, 32'(err_code), 32'(exp_err));
    check({name, "_busy_low"}, 32'(busy), 32'd0);
    check({name, "_tx_count"}, 32'(tx_q.size()), 32'(exp_tx));
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_cmd%0d", name, i),
            (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    non_ff = 0;
    for (int i = 6; i < tx_q.size(); i++) if (tx_q[i] != 8'hFF) non_ff++;
    check({name, "_poll_bytes"}, 32'(non_ff), 32'd0);
    check({name, "_crc_clr"}, 32'(crc_clr_n), 32'(exp_clr));
    check({name, "_dma_wr"}, 32'(dma_wr_n), 32'(exp_dma));
    check({name, "_mode_wr"}, 32'(mode_wr_n), 32'(1 + exp_dma));
    check({name, "_mode_val"}, 32'(mode_bad_n), 32'd0);
    check({name, "_protocol"}, 32'(prot_bad - start_prot), 32'd0);
  endtask

  logic [7:0] r1_pick[5]  = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h01};
  logic [7:0] tok_pick[5] = '{8'hFE, 8'hFE, 8'hFE, 8'h08, 8'h00};

  initial begin
    int cyc, start_done;
    set_scenario(0, 8'h00, 0, 8'hFE, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, err_code, bus_cs, bus_we, bus_a, bus_wd}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op("nominal",   32'h0000_1234, 1, 8'h00, 2, 8'hFE, 1'b0);
    run_op("r1_tmo",    32'hCAFE_0001, 99, 8'h00, 0, 8'hFE, 1'b0);
    run_op("r1_err",    32'h0000_0042, 0, 8'h05, 0, 8'hFE, 1'b0);
    run_op("tok_err",   32'h1111_2222, 2, 8'h00, 1, 8'h08, 1'b0);
    run_op("crc_bad",   32'hABCD_EF01, 0, 8'h00, 0, 8'hFE, 1'b1);
    run_op("r1_last",   32'h0F0F_0F0F, R1_TRIES - 1, 8'h00, 0, 8'hFE, 1'b0);
    run_op("tok_tmo",   32'h7777_8888, 0, 8'h00, 5000, 8'hFE, 1'b0);

    // reset during DMAWAIT
    set_scenario(0, 8'h00, 1, 8'hFE, 1'b0);
    start_done = done_cnt;
    pulse_req(32'h5555_AAAA);
    cyc = 0;
    while (!dma_busy && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reach_dma", 32'(dma_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {busy, done, err_code, bus_cs, bus_we, bus_a, bus_wd}, 32'd0);
    repeat (5) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - start_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 32'h0000_1234, 1, 8'h00, 2, 8'hFE, 1'b0);

    for (int n = 0; n < 10; n++)
      run_op($sformatf("rand%0d", n), $urandom, $urandom_range(0, 9),
             r1_pick[$urandom_range(0, 4)], $urandom_range(0, 20),
             tok_pick[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
